line_clear_engine: RTL and testbench
====================================

Name: line_clear_engine

Overview:
- Parametrised successor to the single-row full-line detector in the Tetris game core.
- On each piece lock, scans the whole board one row per cycle, bottom to top, and compacts it in place through a row write port, so full rows are removed and the rows above drop down.
- Reports per-pass clear count, combo depth and a running line total.
- Maintains a pending-garbage counter for the versus link.
- Sits between the piece-lock logic and the board register file.

Parameters:
- COLS, 10, board width in cells (bits per row).
- ROWS, 20, board height; row 0 is the top row.
- ROW_BITS, 5, width of row indices; must satisfy 2^ROW_BITS >= ROWS.
- CNT_BITS, 6, width of the garbage and combo counters.
- TOT_BITS, 10, width of the running total of cleared lines.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- state_rst  in  1  synchronous game restart.
- start  in  1  piece-lock pulse; begins a pass.
- pause  in  1  freezes FSM and all counters.
- delete  in  1  one garbage line delivered; decrement pending.
- board  in  ROWS*COLS  flattened board; row r = board[r*COLS +: COLS].
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- wr_en  out  1  row write strobe.
- wr_row  out  ROW_BITS  row index to write.
- wr_data  out  COLS  row data to write.
- cleared  out  3  full rows removed in the last pass (0..4).
- combo  out  CNT_BITS  consecutive passes with a clear.
- total_lines  out  TOT_BITS  lines cleared since restart.
- send  out  1  one-cycle pulse when attack > 0.
- attack  out  3  lines sent with this send pulse.
- pending  out  CNT_BITS  garbage lines owed.

Behaviour:
Reset and restart
- rst: all outputs 0 and state IDLE.
- state_rst: same effect synchronously; it overrides everything else in that cycle.

Pause
- pause=1: no state, pointer or counter advances, and wr_en is forced 0.
- Outputs otherwise hold.
- A start seen during pause is dropped.

States
- IDLE: start=1 -> SCAN with r=ROWS-1, w=ROWS-1, and clear count k=0. busy=1 from the next cycle. start is ignored outside IDLE.
- SCAN (one row per cycle):
  - If &board[r] is set: k++, no write.
  - Otherwise, if w!=r: write row r to w (wr_en=1, wr_row=w, wr_data=board[r]); then w-- whenever the row is not full.
  - When r==0, go to FILL if k>0, else to REPORT.
- FILL: write zeros to w, w-- each cycle; after k writes go to REPORT.
- REPORT (1 cycle): updates counters; done=1 and send as specified below; then IDLE with busy=0.

Latency and board ownership
- Pass latency from start to done is ROWS + k + 1 cycles.
- Writes always target rows >= r, so the board owner applies wr_* on the same edge and board is read live.
- The owner must not modify board by any other path while busy.

REPORT updates
- cleared <= k, saturated at 4. More than 4 full rows means the board state is illegal: the count is clipped, but compaction is still full.
- If k>0, combo <= combo+1, saturating at all-ones; if k==0, combo <= 0.
- total_lines adds k, saturating at all-ones.
- base attack: k=1 -> 0, 2 -> 1, 3 -> 2, >=4 -> 4.
- attack = base, +1 if new combo>=2 and k>0, capped at 7.
- send=1 when attack>0; attack is held until the next REPORT.

Pending garbage
- pending_next = pending + (REPORT ? attack : 0) - (delete && operand>0 ? 1 : 0), saturating at all-ones.
- operand is pending plus the attack added this cycle.
- delete with pending=0 and nothing added leaves pending at 0.
- delete is honoured in any state unless paused.

Test Plan:
- Empty board, start -> no wr_en during SCAN, no FILL; done at cycle ROWS+1 with cleared=0, combo=0, send=0.
- Rows 19 and 18 full, row 17 = 10'h155 -> row 17 data written to row 19; zeros written to rows 18 and 17 among others; cleared=2, attack=1, pending=1, total_lines=2, done at cycle 23.
- Three consecutive passes each clearing 1 row -> combo 1,2,3; attack 0,1,1; pending 2. Then a pass with no clears -> combo=0.
- Tetris (rows 16–19 full) with delete asserted in the REPORT cycle and pending=0 -> attack=4, pending=3.
- pause raised mid-SCAN for 5 cycles -> wr_en=0 and row pointer frozen; resumed pass ends with an identical result 5 cycles later. rst asserted mid-FILL -> all outputs 0 immediately, busy=0.
- start pulsed while busy, and state_rst together with delete -> start ignored; state_rst wins with pending=0 and state IDLE.

Source files
------------

// File: rtl/line_clear_engine.sv
// Full-board line clear: scans rows bottom to top on each piece lock, compacts the board in
// place through a row write port, and keeps combo, line-total and garbage bookkeeping.
module line_clear_engine #(
    parameter int unsigned COLS     = 10,
    parameter int unsigned ROWS     = 20,
    parameter int unsigned ROW_BITS = 5,
    parameter int unsigned CNT_BITS = 6,
    parameter int unsigned TOT_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 state_rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 delete,
    input  logic [ROWS*COLS-1:0] board,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_en,
    output logic [ROW_BITS-1:0]  wr_row,
    output logic [COLS-1:0]      wr_data,
    output logic [2:0]           cleared,
    output logic [CNT_BITS-1:0]  combo,
    output logic [TOT_BITS-1:0]  total_lines,
    output logic                 send,
    output logic [2:0]           attack,
    output logic [CNT_BITS-1:0]  pending
);

    localparam int unsigned CntMax = (1 << CNT_BITS) - 1;
    localparam int unsigned TotMax = (1 << TOT_BITS) - 1;
    localparam logic [ROW_BITS-1:0] RowOne  = ROW_BITS'(1);
    localparam logic [ROW_BITS-1:0] RowLast = ROW_BITS'(ROWS - 1);
    localparam logic [ROW_BITS:0]   KOne    = (ROW_BITS + 1)'(1);
    localparam logic [ROW_BITS:0]   KFour   = (ROW_BITS + 1)'(4);
    localparam logic [CNT_BITS-1:0] CntOne  = CNT_BITS'(1);

    typedef enum logic [1:0] {StIdle, StScan, StFill, StReport} state_e;

    state_e              state_q;
    logic [ROW_BITS-1:0] r_q, w_q;
    logic [ROW_BITS:0]   k_q, fill_q;

    logic [COLS-1:0]     cur_row;
    logic                row_full;
    logic [ROW_BITS:0]   k_scan, rep_k;
    logic                enter_report;
    logic [CNT_BITS-1:0] combo_new, pending_new;
    logic [TOT_BITS-1:0] total_new;
    logic [2:0]          cleared_new, base_atk, attack_new;
    logic [3:0]          atk_sum;
    logic                bonus;
    int unsigned         k_int, tot_sum, pend_op, pend_sum;

    always_comb begin
        cur_row   = board[32'(r_q) * COLS +: COLS];
        row_full  = &cur_row;
        k_scan    = row_full ? k_q + KOne : k_q;
        rep_k     = (state_q == StFill) ? k_q : k_scan;
        enter_report = (state_q == StScan && r_q == '0 && k_scan == '0) ||
                       (state_q == StFill && fill_q == KOne);

        k_int     = 32'(rep_k);
        combo_new = (rep_k == '0) ? '0 : ((combo == '1) ? combo : combo + CntOne);
        tot_sum   = 32'(total_lines) + k_int;
        total_new = (tot_sum > TotMax) ? TOT_BITS'(TotMax) : TOT_BITS'(tot_sum);
        cleared_new = (rep_k > KFour) ? 3'd4 : rep_k[2:0];
        if (k_int >= 4)      base_atk = 3'd4;
        else if (k_int == 3) base_atk = 3'd2;
        else if (k_int == 2) base_atk = 3'd1;
        else                 base_atk = 3'd0;
        bonus      = (rep_k != '0) && (combo_new > CntOne);
        atk_sum    = {1'b0, base_atk} + {3'b000, bonus};
        attack_new = (atk_sum > 4'd7) ? 3'd7 : atk_sum[2:0];

        // Attack is added in the REPORT cycle, where the attack register already holds it.
        pend_op     = 32'(pending) + ((state_q == StReport) ? 32'(attack) : 32'd0);
        pend_sum    = pend_op - ((delete && pend_op != 0) ? 32'd1 : 32'd0);
        pending_new = (pend_sum > CntMax) ? CNT_BITS'(CntMax) : CNT_BITS'(pend_sum);
    end

    // Writes go out combinationally so the board owner commits them on the scanning edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        if (!pause && !state_rst) begin
            if (state_q == StScan && !row_full && w_q != r_q) begin
                wr_en   = 1'b1;
                wr_row  = w_q;
                wr_data = cur_row;
            end else if (state_q == StFill) begin
                wr_en  = 1'b1;
                wr_row = w_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            r_q         <= '0;
            w_q         <= '0;
            k_q         <= '0;
            fill_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cleared     <= '0;
            combo       <= '0;
            total_lines <= '0;
            send        <= 1'b0;
            attack      <= '0;
            pending     <= '0;
        end else if (state_rst) begin
            state_q     <= StIdle;
            r_q         <= '0;
            w_q         <= '0;
            k_q         <= '0;
            fill_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cleared     <= '0;
            combo       <= '0;
            total_lines <= '0;
            send        <= 1'b0;
            attack      <= '0;
            pending     <= '0;
        end else if (!pause) begin
            pending <= pending_new;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StScan;
                        r_q     <= RowLast;
                        w_q     <= RowLast;
                        k_q     <= '0;
                        busy    <= 1'b1;
                    end
                end
                StScan: begin
                    k_q <= k_scan;
                    if (!row_full) w_q <= w_q - RowOne;
                    if (r_q == '0) begin
                        if (k_scan != '0) begin
                            state_q <= StFill;
                            fill_q  <= k_scan;
                        end else begin
                            state_q <= StReport;
                        end
                    end else begin
                        r_q <= r_q - RowOne;
                    end
                end
                StFill: begin
                    w_q    <= w_q - RowOne;
                    fill_q <= fill_q - KOne;
                    if (fill_q == KOne) state_q <= StReport;
                end
                StReport: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    send    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
            if (enter_report) begin
                done        <= 1'b1;
                cleared     <= cleared_new;
                combo       <= combo_new;
                total_lines <= total_new;
                attack      <= attack_new;
                send        <= (attack_new != '0);
            end
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: models the board owner, predicts each pass into a
// scoreboard queue and compares when done pulses.
module tb_line_clear_engine;

    localparam int unsigned COLS     = 10;
    localparam int unsigned ROWS     = 20;
    localparam int unsigned ROW_BITS = 5;
    localparam int unsigned CNT_BITS = 6;
    localparam int unsigned TOT_BITS = 10;
    localparam int CMAX = (1 << CNT_BITS) - 1;
    localparam int TMAX = (1 << TOT_BITS) - 1;

    logic                 clk, rst, state_rst, start, pause, delete;
    logic [ROWS*COLS-1:0] board_q, load_val, b;
    logic                 load_en;
    logic                 busy, done, wr_en, send;
    logic [ROW_BITS-1:0]  wr_row;
    logic [COLS-1:0]      wr_data;
    logic [2:0]           cleared, attack;
    logic [CNT_BITS-1:0]  combo, pending;
    logic [TOT_BITS-1:0]  total_lines;

    typedef struct {
        int lat; int cleared; int combo; int total; int attack; int send; int pending;
        int writes;
        logic [ROWS*COLS-1:0] board;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_combo, m_total, m_pending;
    logic [ROWS*COLS-1:0] m_board;

    line_clear_engine #(
        .COLS(COLS), .ROWS(ROWS), .ROW_BITS(ROW_BITS), .CNT_BITS(CNT_BITS), .TOT_BITS(TOT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .state_rst(state_rst), .start(start), .pause(pause),
        .delete(delete), .board(board_q), .busy(busy), .done(done), .wr_en(wr_en),
        .wr_row(wr_row), .wr_data(wr_data), .cleared(cleared), .combo(combo),
        .total_lines(total_lines), .send(send), .attack(attack), .pending(pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Board owner: commits row writes on the same edge the engine scans.
    always @(posedge clk) begin
        if (load_en) board_q <= load_val;
        else if (wr_en) board_q[32'(wr_row) * COLS +: COLS] <= wr_data;
    end

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, int'(busy), 0);
        check({pfx, "_done"}, int'(done), 0);
        check({pfx, "_wr_en"}, int'(wr_en), 0);
        check({pfx, "_wr_row"}, int'(wr_row), 0);
        check({pfx, "_wr_data"}, int'(wr_data), 0);
        check({pfx, "_cleared"}, int'(cleared), 0);
        check({pfx, "_combo"}, int'(combo), 0);
        check({pfx, "_total"}, int'(total_lines), 0);
        check({pfx, "_send"}, int'(send), 0);
        check({pfx, "_attack"}, int'(attack), 0);
        check({pfx, "_pending"}, int'(pending), 0);
    endtask

    task automatic load_board(input logic [ROWS*COLS-1:0] nb);
        load_val = nb;
        load_en  = 1'b1;
        @(posedge clk); #1;
        load_en  = 1'b0;
        m_board  = nb;
    endtask

    // Reference model of one full pass, including counter and garbage bookkeeping.
    task automatic model_pass(input bit del_rep, input int pause_len, output exp_t e);
        int k, w, base, atk, op;
        logic [COLS-1:0] row;
        k = 0; w = ROWS - 1; e.writes = 0; e.board = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = m_board[r*COLS +: COLS];
            if (&row) k++;
            else begin
                if (w != r) e.writes++;
                e.board[w*COLS +: COLS] = row;
                w--;
            end
        end
        e.writes += k;
        e.lat     = ROWS + k + 1 + pause_len;
        e.cleared = (k > 4) ? 4 : k;
        m_combo   = (k == 0) ? 0 : ((m_combo == CMAX) ? CMAX : m_combo + 1);
        m_total   = (m_total + k > TMAX) ? TMAX : m_total + k;
        base      = (k >= 4) ? 4 : (k == 3) ? 2 : (k == 2) ? 1 : 0;
        atk       = base + ((k > 0 && m_combo >= 2) ? 1 : 0);
        atk       = (atk > 7) ? 7 : atk;
        op        = m_pending + atk;
        op        = op - ((del_rep && op > 0) ? 1 : 0);
        m_pending = (op > CMAX) ? CMAX : op;
        e.combo = m_combo; e.total = m_total; e.attack = atk; e.send = (atk > 0) ? 1 : 0;
        e.pending = m_pending;
        m_board = e.board;
    endtask

    task automatic run_pass(input bit del_rep, input bit start_mid, input int pause_at,
                            input int pause_len);
        exp_t e;
        int   lat, wr_cnt;
        bit   paused;
        model_pass(del_rep, pause_len, e);
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 1;
        wr_cnt = 0;
        paused = 1'b0;
        while (lat < 300) begin
            if (lat == pause_at && !paused) begin
                pause = 1'b1;
                repeat (pause_len) begin
                    @(negedge clk);
                    check("pause_wr_en", int'(wr_en), 0);
                    @(posedge clk); #1;
                end
                pause  = 1'b0;
                paused = 1'b1;
                lat += pause_len;
            end
            start = start_mid && (lat == 4);
            @(negedge clk);
            if (wr_en) wr_cnt++;
            if (done) break;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", int'(done), 1);
        if (del_rep) delete = 1'b1;
        e = exp_q.pop_front();
        check("latency", lat, e.lat);
        check("cleared", int'(cleared), e.cleared);
        check("combo", int'(combo), e.combo);
        check("total_lines", int'(total_lines), e.total);
        check("attack", int'(attack), e.attack);
        check("send", int'(send), e.send);
        check("busy_in_report", int'(busy), 1);
        check("write_count", wr_cnt, e.writes);
        @(posedge clk); #1;
        delete = 1'b0;
        @(negedge clk);
        check("done_pulse_end", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("send_pulse_end", int'(send), 0);
        check("pending", int'(pending), e.pending);
        checks++;
        assert (board_q === e.board) else begin
            failures++;
            $error("FAIL board observed=%0h expected=%0h", board_q, e.board);
        end
    endtask

    initial begin
        rst = 1'b1; state_rst = 1'b0; start = 1'b0; pause = 1'b0; delete = 1'b0;
        load_en = 1'b0; load_val = '0;
        m_combo = 0; m_total = 0; m_pending = 0;
        load_board('0);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty board: no writes, no fill.
        run_pass(1'b0, 1'b0, 0, 0);

        // Two bottom rows full, one pattern row drops by two.
        b = '0;
        b[19*COLS +: COLS] = '1;
        b[18*COLS +: COLS] = '1;
        b[17*COLS +: COLS] = 10'h155;
        load_board(b);
        run_pass(1'b0, 1'b0, 0, 0);

        // Restart together with delete and start: restart wins, nothing launches.
        state_rst = 1'b1; delete = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        state_rst = 1'b0; delete = 1'b0; start = 1'b0;
        m_combo = 0; m_total = 0; m_pending = 0;
        @(negedge clk);
        check_zero("restart");

        // Three single-line clears build a combo; start pulsed mid-pass on the second.
        for (int i = 0; i < 3; i++) begin
            b = '0;
            b[19*COLS +: COLS] = '1;
            b[(10 + i)*COLS +: COLS] = COLS'(32'h2a5 + i);
            load_board(b);
            run_pass(1'b0, i == 1, 0, 0);
        end
        check("combo_after_three", int'(combo), 3);
        check("pending_after_three", int'(pending), 2);

        // No clear breaks the combo.
        load_board('0);
        run_pass(1'b0, 1'b0, 0, 0);
        check("combo_reset_by_miss", int'(combo), 0);

        // Drain pending; a delete at zero leaves it at zero.
        for (int i = 0; i < 3; i++) begin
            delete = 1'b1;
            @(posedge clk); #1;
            delete = 1'b0;
            m_pending = (m_pending > 0) ? m_pending - 1 : 0;
            @(negedge clk);
            check("delete_pending", int'(pending), m_pending);
        end

        // Start during pause is dropped.
        pause = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        pause = 1'b0; start = 1'b0;
        @(negedge clk);
        check("paused_start_busy", int'(busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("paused_start_busy_later", int'(busy), 0);

        // Tetris with delete in the REPORT cycle.
        b = '0;
        for (int r = 16; r < 20; r++) b[r*COLS +: COLS] = '1;
        b[15*COLS +: COLS] = 10'h0f0;
        load_board(b);
        run_pass(1'b1, 1'b0, 0, 0);
        check("tetris_attack", int'(attack), 4);
        check("tetris_pending", int'(pending), 3);

        // Pause for five cycles mid-scan on a busy board.
        b = '0;
        for (int r = 0; r < 15; r++) b[r*COLS +: COLS] = COLS'($urandom_range(0, (1 << COLS) - 2));
        b[19*COLS +: COLS] = '1;
        b[12*COLS +: COLS] = '1;
        load_board(b);
        run_pass(1'b0, 1'b0, 6, 5);

        // Asynchronous reset in the middle of FILL.
        b = '0;
        for (int r = 17; r < 20; r++) b[r*COLS +: COLS] = '1;
        load_board(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        @(negedge clk);
        check("fill_wr_en", int'(wr_en), 1);
        check("fill_wr_row", int'(wr_row), 1);
        check("fill_wr_data", int'(wr_data), 0);
        rst = 1'b1;
        #1;
        check_zero("rst_mid_fill");
        @(negedge clk);
        rst = 1'b0;
        m_combo = 0; m_total = 0; m_pending = 0;
        @(posedge clk); #1;

        // Clean pass after reset.
        load_board('0);
        run_pass(1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
